// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780-over-PCF8574 sequencer: expander bit map,
// command codes, the 4-bit-mode init table and the FSM state encodings.
package lcd_pkg;

   localparam int BIT_BL = 3;
   localparam int BIT_E  = 2;
   localparam int BIT_RW = 1;
   localparam int BIT_RS = 0;

   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;

   localparam int INIT_LEN = 12;
   localparam logic [0:INIT_LEN-1][3:0]  INIT_NIB = {
      4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h1, 4'h0, 4'hC, 4'h0, 4'h6};
   localparam logic [0:INIT_LEN-1][31:0] INIT_US = {
      32'd4100, 32'd100, 32'd100, 32'd100, 32'd0, 32'd53,
      32'd0, 32'd3000, 32'd0, 32'd53, 32'd0, 32'd53};

   typedef enum logic [2:0] {T_PWR_WAIT, T_INIT, T_READY, T_SEND_HI, T_SEND_LO} top_state_t;
   typedef enum logic [2:0] {W_OFF, W_IDLE, W_REQ, W_ACK, W_GAP, W_POST} wr_state_t;

   // Clear and both home encodings (0x02/0x03) need the long execution delay.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
      return !rs && ((b == CMD_CLEAR) || (b == CMD_HOME) || (b == (CMD_HOME | 8'h01)));
   endfunction

   function automatic logic [7:0] exp_byte(input logic [3:0] nib, input logic e, input logic rs);
      logic [7:0] b;
      b         = {nib, 4'b0000};
      b[BIT_BL] = 1'b1;
      b[BIT_E]  = e;
      b[BIT_RW] = 1'b0;
      b[BIT_RS] = rs;
      return b;
   endfunction

endpackage

// File: rtl/lcd_i2c_sequencer_if.sv
// Byte request stream plus the write side of the simple_i2c master.
// master = the sequencer, slave = requester and i2c master.
interface lcd_i2c_sequencer_if;
   logic       in_valid;
   logic       in_ready;
   logic       in_rs;
   logic [7:0] in_byte;
   logic       i2c_we;
   logic [7:0] i2c_addr;
   logic [7:0] i2c_data;
   logic       i2c_busy;

   modport master (
      input  in_valid, in_rs, in_byte, i2c_busy,
      output in_ready, i2c_we, i2c_addr, i2c_data
   );

   modport slave (
      output in_valid, in_rs, in_byte, i2c_busy,
      input  in_ready, i2c_we, i2c_addr, i2c_data
   );
endinterface

// File: rtl/lcd_nibble_tx.sv
// One nibble = E-high write, enable gap, E-low write, post-delay; start/done handshake.
// Stalls indefinitely while i2c_busy is high; delay counters freeze during busy.
module lcd_nibble_tx
   import lcd_pkg::*;
#(
   parameter int unsigned EN_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic [3:0]  i_nib,
   input  logic        i_rs,
   input  logic [31:0] i_post_cyc,
   input  logic        i_busy,
   output logic        o_idle,
   output logic        o_done,
   output logic        o_we,
   output logic [7:0]  o_data
);

   wr_state_t   r_state;
   wr_state_t   w_next;
   logic        r_hi;
   logic [3:0]  r_nib;
   logic        r_rs;
   logic [31:0] r_post_cyc;
   logic [31:0] r_cnt;
   logic [7:0]  r_data;
   logic        w_cnt_last;

   assign w_cnt_last = !i_busy && (r_cnt == 32'd1);

   always_ff @(posedge clk) begin
      if (rst) r_state <= W_OFF;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         W_OFF:  if (i_start) w_next = W_IDLE;
         W_IDLE: if (!i_busy) w_next = W_REQ;
         W_REQ:  if (i_busy)  w_next = W_ACK;
         W_ACK:
            if (!i_busy) begin
               if (r_hi) w_next = (EN_CYC == 0) ? W_IDLE : W_GAP;
               else      w_next = (r_post_cyc == 32'd0) ? W_OFF : W_POST;
            end
         W_GAP:  if (w_cnt_last) w_next = W_IDLE;
         W_POST: if (w_cnt_last) w_next = W_OFF;
         default: w_next = W_OFF;
      endcase
   end

   always_comb begin
      o_we   = (r_state == W_REQ);
      o_idle = (r_state == W_OFF);
      o_done = ((r_state == W_POST) && w_cnt_last) ||
               ((r_state == W_ACK) && !i_busy && !r_hi && (r_post_cyc == 32'd0));
      o_data = r_data;
   end

   // Expander byte is loaded only on entry to W_REQ, so it is frozen while we is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi       <= 1'b0;
         r_nib      <= 4'h0;
         r_rs       <= 1'b0;
         r_post_cyc <= 32'd0;
         r_cnt      <= 32'd0;
         r_data     <= 8'h08;
      end else begin
         if ((r_state == W_OFF) && i_start) begin
            r_hi       <= 1'b1;
            r_nib      <= i_nib;
            r_rs       <= i_rs;
            r_post_cyc <= i_post_cyc;
         end
         if ((r_state == W_IDLE) && !i_busy)
            r_data <= exp_byte(r_nib, r_hi, r_rs);
         if ((r_state == W_ACK) && !i_busy) begin
            r_cnt <= r_hi ? EN_CYC : r_post_cyc;
            r_hi  <= 1'b0;
         end else if (((r_state == W_GAP) || (r_state == W_POST)) && !i_busy) begin
            r_cnt <= r_cnt - 32'd1;
         end
      end
   end

endmodule

// File: rtl/lcd_i2c_sequencer.sv
// HD44780 4-bit sequencer over a PCF8574 backpack: power-up wait, 12-step init, then byte stream.
// in_ready only in READY; every byte costs two nibbles plus the HD44780 execution delay.
module lcd_i2c_sequencer
   import lcd_pkg::*;
#(
   parameter int unsigned US_CYCLES  = 100,
   parameter logic [7:0]  EXP_ADDR   = 8'h27,
   parameter int unsigned POWERUP_US = 40000,
   parameter int unsigned EN_US      = 1,
   parameter int unsigned SHORT_US   = 53,
   parameter int unsigned LONG_US    = 3000
) (
   input  logic                  clk,
   input  logic                  rst,
   lcd_i2c_sequencer_if.master   bus,
   output logic                  init_done,
   output logic                  busy
);

   localparam logic [3:0] LAST_IDX = 4'(INIT_LEN - 1);

   top_state_t  r_state;
   top_state_t  w_next;
   logic [31:0] r_pwr_cnt;
   logic [3:0]  r_idx;
   logic        r_rs;
   logic [7:0]  r_byte;
   logic        r_init_done;

   logic        w_start;
   logic [3:0]  w_nib;
   logic        w_rs;
   logic [31:0] w_post_cyc;
   logic        w_idle;
   logic        w_done;
   logic        w_we;
   logic [7:0]  w_data;
   logic        w_in_ready;

   lcd_nibble_tx #(.EN_CYC(EN_US * US_CYCLES)) u_nibble_tx (
      .clk        (clk),
      .rst        (rst),
      .i_start    (w_start),
      .i_nib      (w_nib),
      .i_rs       (w_rs),
      .i_post_cyc (w_post_cyc),
      .i_busy     (bus.i2c_busy),
      .o_idle     (w_idle),
      .o_done     (w_done),
      .o_we       (w_we),
      .o_data     (w_data)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= T_PWR_WAIT;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         T_PWR_WAIT: if (r_pwr_cnt == 32'd0)               w_next = T_INIT;
         T_INIT:     if (w_done && (r_idx == LAST_IDX))    w_next = T_READY;
         T_READY:    if (bus.in_valid)                     w_next = T_SEND_HI;
         T_SEND_HI:  if (w_done)                           w_next = T_SEND_LO;
         T_SEND_LO:  if (w_done)                           w_next = T_READY;
         default:                                          w_next = T_PWR_WAIT;
      endcase
   end

   // A nibble is launched whenever a sending state finds the engine idle.
   always_comb begin
      w_in_ready = (r_state == T_READY);
      w_start    = 1'b0;
      w_nib      = r_byte[7:4];
      w_rs       = r_rs;
      w_post_cyc = 32'd0;
      case (r_state)
         T_INIT: begin
            w_start    = w_idle;
            w_nib      = INIT_NIB[r_idx];
            w_rs       = 1'b0;
            w_post_cyc = INIT_US[r_idx] * US_CYCLES;
         end
         T_SEND_HI: w_start = w_idle;
         T_SEND_LO: begin
            w_start    = w_idle;
            w_nib      = r_byte[3:0];
            w_post_cyc = is_long_cmd(r_rs, r_byte) ? (LONG_US * US_CYCLES) : (SHORT_US * US_CYCLES);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pwr_cnt   <= POWERUP_US * US_CYCLES;
         r_idx       <= 4'd0;
         r_rs        <= 1'b0;
         r_byte      <= 8'h00;
         r_init_done <= 1'b0;
      end else begin
         if ((r_state == T_PWR_WAIT) && (r_pwr_cnt != 32'd0))
            r_pwr_cnt <= r_pwr_cnt - 32'd1;
         if ((r_state == T_INIT) && w_done) begin
            r_idx <= r_idx + 4'd1;
            if (r_idx == LAST_IDX) r_init_done <= 1'b1;
         end
         if ((r_state == T_READY) && bus.in_valid) begin
            r_rs   <= bus.in_rs;
            r_byte <= bus.in_byte;
         end
      end
   end

   assign bus.in_ready = w_in_ready;
   assign bus.i2c_we   = w_we;
   assign bus.i2c_addr = EXP_ADDR;
   assign bus.i2c_data = w_data;
   assign init_done    = r_init_done;
   assign busy         = !w_in_ready;

endmodule
